// File: rtl/dl_rr_arb3_pkg.sv
// Shared definitions for the three-requester round-robin arbiter and its payload mux.
package dl_rr_arb3_pkg;

   localparam int NUM_REQ = 3;

   typedef logic [1:0] req_idx_t;

   // Modulo-3 add of two requester indices; both operands are always in 0..2.
   function automatic req_idx_t idx_add(input req_idx_t a, input req_idx_t b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? req_idx_t'(s - 3'd3) : req_idx_t'(s);
   endfunction

endpackage

// File: rtl/dl_rr_arb3_mux3.sv
// Three-way payload selector; an out-of-range select yields zero.
module dl_mux3
   import dl_rr_arb3_pkg::*;
#(
   parameter int NUM_BITS = 32
) (
   input  req_idx_t            sel,
   input  logic [NUM_BITS-1:0] d0,
   input  logic [NUM_BITS-1:0] d1,
   input  logic [NUM_BITS-1:0] d2,
   output logic [NUM_BITS-1:0] y
);

   always_comb begin
      y = '0;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/dl_rr_arb3.sv
// Three-requester round-robin arbiter feeding a single registered output slot.
module dl_rr_arb3
   import dl_rr_arb3_pkg::*;
#(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in0_valid,
   input  logic                in1_valid,
   input  logic                in2_valid,
   input  logic [NUM_BITS-1:0] in0_data,
   input  logic [NUM_BITS-1:0] in1_data,
   input  logic [NUM_BITS-1:0] in2_data,
   output logic                in0_ready,
   output logic                in1_ready,
   output logic                in2_ready,
   output logic                out_valid,
   output logic [NUM_BITS-1:0] out_data,
   output logic [1:0]          out_src,
   input  logic                out_ready
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; ready never looks at data, and out_valid/out_data/out_src
   // stay stable while out_valid is high and out_ready is low.

   req_idx_t            ptr_q, ptr_d;
   logic                out_valid_q, out_valid_d;
   logic [NUM_BITS-1:0] out_data_q, out_data_d;
   req_idx_t            out_src_q, out_src_d;

   logic [NUM_REQ-1:0]  valid_vec;
   logic [NUM_REQ-1:0]  rot;
   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  ready_vec;
   req_idx_t            offs;
   req_idx_t            win_idx;
   logic                slot_free;
   logic                accept;
   logic [NUM_BITS-1:0] mux_y;

   assign valid_vec = {in2_valid, in1_valid, in0_valid};

   // Rotate the requests so bit 0 is the current highest-priority requester.
   always_comb begin
      rot = valid_vec;
      case (ptr_q)
         2'd1:    rot = {valid_vec[0], valid_vec[2], valid_vec[1]};
         2'd2:    rot = {valid_vec[1], valid_vec[0], valid_vec[2]};
         default: rot = valid_vec;
      endcase
      if (rot[0])      offs = 2'd0;
      else if (rot[1]) offs = 2'd1;
      else             offs = 2'd2;
      win_idx = idx_add(ptr_q, offs);
      grant   = '0;
      if (|valid_vec) grant[win_idx] = 1'b1;
   end

   assign slot_free = !out_valid_q || out_ready;
   assign ready_vec = grant & {NUM_REQ{slot_free && rst_n}};
   assign accept    = |ready_vec;

   dl_mux3 #(.NUM_BITS(NUM_BITS)) u_mux (
      .sel (win_idx),
      .d0  (in0_data),
      .d1  (in1_data),
      .d2  (in2_data),
      .y   (mux_y)
   );

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = mux_y;
         out_src_d   = win_idx;
         ptr_d       = idx_add(win_idx, 2'd1);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 2'd0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign in0_ready = ready_vec[0];
   assign in1_ready = ready_vec[1];
   assign in2_ready = ready_vec[2];
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_dl_rr_arb3.sv
// Directed bench for dl_rr_arb3: stimulus pushes expected beats, a monitor pops them.
module tb_dl_rr_arb3;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         in0_valid, in1_valid, in2_valid;
   logic [W-1:0] in0_data, in1_data, in2_data;
   logic         in0_ready, in1_ready, in2_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_src;
   logic         out_ready;

   int errors = 0;
   int checks = 0;

   logic [W+1:0] exp_q[$];

   dl_rr_arb3 #(.NUM_BITS(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in1_valid (in1_valid),
      .in2_valid (in2_valid),
      .in0_data  (in0_data),
      .in1_data  (in1_data),
      .in2_data  (in2_data),
      .in0_ready (in0_ready),
      .in1_ready (in1_ready),
      .in2_ready (in2_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rdy();
      return {{(W-3){1'b0}}, in2_ready, in1_ready, in0_ready};
   endfunction

   // driver tasks
   task automatic set_in(input logic [2:0] v, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic [W-1:0] d2);
      {in2_valid, in1_valid, in0_valid} = v;
      in0_data = d0;
      in1_data = d1;
      in2_data = d2;
   endtask

   task automatic push(input logic [1:0] src, input logic [W-1:0] data);
      exp_q.push_back({src, data});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // scoreboard monitor: one expected beat per consumed output
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got src=%0d data=%0h with no expected beat", out_src, out_data);
         end else begin
            logic [W+1:0] e;
            e = exp_q.pop_front();
            chk("sb_src", {{(W-2){1'b0}}, out_src}, {{(W-2){1'b0}}, e[W+1:W]});
            chk("sb_data", out_data, e[W-1:0]);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      set_in(3'b111, 32'h11, 32'h22, 32'h33);

      // reset state, ready held low even with requests present
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_src", {30'd0, out_src}, 32'd0);
      chk("rst_ready", rdy(), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // all three continuously valid: 0,1,2,0,1,2
      set_in(3'b111, 32'hA0, 32'hA1, 32'hA2);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_ready", rdy(), 32'd1 << (k % 3));
         if (k > 0) chk("rr_out_valid", {31'd0, out_valid}, 32'd1);
         push(2'(k % 3), 32'hA0 + 32'(k % 3));
         next_cycle();
      end
      set_in(3'b000, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      chk("rr_drain_valid", {31'd0, out_valid}, 32'd0);
      chk("rr_ptr", {30'd0, dut.ptr_q}, 32'd0);
      next_cycle();

      // single requester 1
      set_in(3'b010, 32'h0, 32'hA5A5A5A5, 32'h0);
      @(negedge clk);
      chk("one_ready", rdy(), 32'b010);
      push(2'd1, 32'hA5A5A5A5);
      next_cycle();
      set_in(3'b000, 0, 0, 0);
      @(negedge clk);
      chk("one_out_valid", {31'd0, out_valid}, 32'd1);
      chk("one_ptr", {30'd0, dut.ptr_q}, 32'd2);
      next_cycle();

      // ptr=2 with 0 and 2 requesting: 2 first, then wrap to 0
      set_in(3'b101, 32'hC0, 32'h0, 32'hC2);
      @(negedge clk);
      chk("wrap_ready2", rdy(), 32'b100);
      push(2'd2, 32'hC2);
      next_cycle();
      @(negedge clk);
      chk("wrap_ptr0", {30'd0, dut.ptr_q}, 32'd0);
      chk("wrap_ready0", rdy(), 32'b001);
      push(2'd0, 32'hC0);
      next_cycle();
      set_in(3'b000, 0, 0, 0);
      next_cycle();

      // stall: fill slot with out_ready low, then hold for 4 cycles
      out_ready = 1'b0;
      set_in(3'b010, 32'h0, 32'hD1, 32'h0);
      @(negedge clk);
      chk("stall_fill_ready", rdy(), 32'b010);
      push(2'd1, 32'hD1);
      next_cycle();
      set_in(3'b101, 32'hE0, 32'h0, 32'hE2);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_ready", rdy(), 32'd0);
         chk("stall_valid", {31'd0, out_valid}, 32'd1);
         chk("stall_data", out_data, 32'hD1);
         chk("stall_src", {30'd0, out_src}, 32'd1);
         next_cycle();
      end
      set_in(3'b001, 32'hE0, 32'h0, 32'hE2);
      @(negedge clk);
      chk("drop_ready", rdy(), 32'd0);
      next_cycle();
      set_in(3'b000, 0, 0, 0);
      @(negedge clk);
      chk("drop_ptr", {30'd0, dut.ptr_q}, 32'd2);
      chk("drop_data", out_data, 32'hD1);
      next_cycle();

      // release stall: back-to-back transfers in ptr order 2, 0
      out_ready = 1'b1;
      set_in(3'b101, 32'hE0, 32'h0, 32'hE2);
      @(negedge clk);
      chk("release_ready2", rdy(), 32'b100);
      push(2'd2, 32'hE2);
      next_cycle();
      @(negedge clk);
      chk("release_ready0", rdy(), 32'b001);
      chk("release_valid", {31'd0, out_valid}, 32'd1);
      push(2'd0, 32'hE0);
      next_cycle();
      set_in(3'b000, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      chk("release_idle", {31'd0, out_valid}, 32'd0);
      chk("release_ptr", {30'd0, dut.ptr_q}, 32'd1);
      next_cycle();

      // asynchronous reset while a payload is held (not expected downstream)
      out_ready = 1'b0;
      set_in(3'b100, 32'h0, 32'h0, 32'hF2);
      next_cycle();
      set_in(3'b111, 32'h60, 32'h61, 32'h62);
      @(negedge clk);
      chk("held_valid", {31'd0, out_valid}, 32'd1);
      chk("held_data", out_data, 32'hF2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_data", out_data, 32'd0);
      chk("arst_src", {30'd0, out_src}, 32'd0);
      chk("arst_ptr", {30'd0, dut.ptr_q}, 32'd0);
      chk("arst_ready", rdy(), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", rdy(), 32'b001);
      push(2'd0, 32'h60);
      next_cycle();
      set_in(3'b000, 0, 0, 0);
      next_cycle();
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dl_rr_arb3.md
DL_RR_ARB3 -- requirements
Module: dl_rr_arb3

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, giving the payload width per requester.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in0_valid, in1_valid, in2_valid  input  1 each  requester i offers a payload.
REQ-005 SHALL have ports in0_data, in1_data, in2_data  input  NUM_BITS each  requester payloads.
REQ-006 SHALL have ports in0_ready, in1_ready, in2_ready  output  1 each  payload i accepted this cycle.
REQ-007 SHALL have port out_valid  output  1  output register holds a payload.
REQ-008 SHALL have port out_data  output  NUM_BITS  registered winning payload.
REQ-009 SHALL have port out_src  output  2  index (0..2) of the requester that supplied out_data.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_data when out_valid is high.

Function
REQ-011 SHALL hold a 2-bit round-robin pointer ptr in {0,1,2} naming the highest-priority requester; priority order is ptr, ptr+1, ptr+2 (mod 3).
REQ-012 SHALL compute a combinational one-hot grant: the highest-priority requester with valid high; no grant when no valid is high.
REQ-013 SHALL define slot_free = !out_valid || out_ready.
REQ-014 SHALL drive in_i_ready = grant_i && slot_free; at most one in_ready high per cycle; in_ready never depends on in_data.
REQ-015 On accept (in_i_valid && in_i_ready), SHALL load out_data <= in_i_data and out_src <= i, and set out_valid <= 1 at the next edge (latency 1 cycle).
REQ-016 On accept from i, SHALL update ptr <= (i+1) mod 3, wrapping 2 -> 0; ptr SHALL be unchanged in cycles without an accept.
REQ-017 When out_valid && out_ready and no accept occurs, SHALL clear out_valid at the next edge; out_data and out_src may hold stale values.
REQ-018 When out_valid && out_ready and an accept occurs in the same cycle, SHALL keep out_valid high and replace the contents, sustaining one transfer per cycle.
REQ-019 When out_valid && !out_ready, SHALL hold out_valid, out_data and out_src stable, with all in_ready low.
REQ-020 A requester that drops valid before acceptance SHALL lose its grant with no state change; the grant is not locked.
REQ-021 SHALL guarantee any continuously valid requester is accepted within 3 accepts.
REQ-022 SHALL drive out_src only with values 0..2; value 3 is never produced.

Reset
REQ-023 While rst_n is low, SHALL force out_valid=0, out_data=0, out_src=0 and ptr=0, asynchronously.
REQ-024 Reset mid-transfer SHALL discard the held payload without handshake; in_ready SHALL be low during reset.
REQ-025 After rst_n rises, the first accept SHALL follow priority 0,1,2.

Structure
REQ-026 SHALL place the requester count (3) and a 2-bit requester-index typedef in the shared design-library package; NUM_BITS stays a module parameter.
REQ-027 SHALL instantiate one dl_mux3 (NUM_BITS wide) with sel = encoded grant to pick the payload to register.
REQ-028 SHALL keep grant and ptr-update logic in this module; no further sub-modules.

Verification
REQ-029 Reset, then all three valid continuously with out_ready=1 -> out_src sequence 0,1,2,0,1,2, out_valid high every cycle after the first.
REQ-030 Only in1 valid (data 0xA5A5A5A5), out_ready=1 -> in1_ready high the same cycle; next cycle out_valid=1, out_data=0xA5A5A5A5, out_src=1; ptr=2.
REQ-031 out_ready=0 with out_valid=1 and in0, in2 valid for 4 cycles -> all in_ready low, out_data/out_src stable; on out_ready=1 the next accept follows ptr order.
REQ-032 ptr=2, in0 and in2 valid -> in2 granted, then ptr wraps to 0 and in0 granted next.
REQ-033 rst_n low while out_valid=1 -> out_valid=0, out_data=0 and ptr=0 immediately without a clock edge; the first accept after release goes to in0 when all are valid.
REQ-034 in0 valid for 1 cycle while out_valid && !out_ready, then dropped -> no accept and ptr unchanged.
